// File: rtl/time_counters_pkg.sv
// Shared constants and the BCD helper for the timekeeping datapath.
package time_counters_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    localparam int EN_SEC  = 0;
    localparam int EN_MIN  = 1;
    localparam int EN_HOUR = 2;

    // Next packed-BCD value; the caller handles the full-range wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after MAX_BCD.
module bcd_mod_counter
    import time_counters_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Clear,
    input  logic       i_Inc,
    output logic [7:0] o_Value,
    output logic       o_Wrap
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Next value: clear beats increment, full-range wrap beats the digit rule.
    always_comb begin
        value_d = value_q;
        if (i_Clear) begin
            value_d = 8'h00;
        end else if (i_Inc) begin
            if (value_q == MAX_BCD) begin
                value_d = 8'h00;
            end else begin
                value_d = bcd_inc(value_q);
            end
        end else begin
            value_d = value_q;
        end
    end

    // Value register.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_Value = value_q;
    assign o_Wrap  = i_Inc & (value_q == MAX_BCD);

endmodule

// File: rtl/time_counters.sv
// Seconds/minutes/hours datapath with a per-second prescaler and a manual-set prescaler.
module time_counters
    import time_counters_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int INC_TICKS     = 50_000_000
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Counters_Reset,
    input  logic       i_Counters_Enable_Increment,
    input  logic [2:0] i_Counters_Enable_Count,
    output logic [7:0] o_Seconds,
    output logic [7:0] o_Minutes,
    output logic [7:0] o_Hours,
    output logic       o_Second_Tick
);

    localparam int SW = $clog2(TICKS_PER_SEC);
    localparam int IW = $clog2(INC_TICKS);
    localparam logic [SW-1:0] SEC_LAST = SW'(TICKS_PER_SEC - 1);
    localparam logic [IW-1:0] INC_LAST = IW'(INC_TICKS - 1);

    logic [SW-1:0] sec_pre_q, sec_pre_d;
    logic [IW-1:0] inc_pre_q, inc_pre_d;
    logic          tick_q, tick_d;
    logic          sec_clr_s, sec_step_s, set_fire_s;
    logic          sec_inc_s, min_inc_s, hour_inc_s;
    logic          sec_wrap_s, min_wrap_s, hour_wrap_s;

    // Prescaler next state and the raw seconds step / set-mode fire events.
    always_comb begin
        sec_pre_d  = sec_pre_q;
        inc_pre_d  = inc_pre_q;
        tick_d     = 1'b0;
        sec_clr_s  = 1'b0;
        sec_step_s = 1'b0;
        set_fire_s = 1'b0;
        if (i_Counters_Reset) begin
            sec_clr_s = 1'b1;
            sec_pre_d = '0;
            inc_pre_d = '0;
        end else if (i_Counters_Enable_Increment) begin
            if (inc_pre_q == INC_LAST) begin
                inc_pre_d  = '0;
                set_fire_s = 1'b1;
            end else begin
                inc_pre_d = inc_pre_q + 1'b1;
            end
        end else begin
            inc_pre_d = '0;
            if (i_Counters_Enable_Count[EN_SEC]) begin
                if (sec_pre_q == SEC_LAST) begin
                    sec_pre_d  = '0;
                    sec_step_s = 1'b1;
                    tick_d     = 1'b1;
                end else begin
                    sec_pre_d = sec_pre_q + 1'b1;
                end
            end else begin
                sec_pre_d = sec_pre_q;
            end
        end
    end

    // Set mode bumps each enabled field on its own; normal mode ripples carries.
    assign sec_inc_s  = set_fire_s ? i_Counters_Enable_Count[EN_SEC] : sec_step_s;
    assign min_inc_s  = set_fire_s ? i_Counters_Enable_Count[EN_MIN]
                                   : (sec_wrap_s & i_Counters_Enable_Count[EN_MIN]);
    assign hour_inc_s = set_fire_s ? i_Counters_Enable_Count[EN_HOUR]
                                   : (min_wrap_s & i_Counters_Enable_Count[EN_HOUR]);

    // Prescalers and the registered tick.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            sec_pre_q <= '0;
            inc_pre_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            sec_pre_q <= sec_pre_d;
            inc_pre_q <= inc_pre_d;
            tick_q    <= tick_d;
        end
    end

    bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_seconds (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (sec_clr_s),
        .i_Inc     (sec_inc_s),
        .o_Value   (o_Seconds),
        .o_Wrap    (sec_wrap_s)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_minutes (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (1'b0),
        .i_Inc     (min_inc_s),
        .o_Value   (o_Minutes),
        .o_Wrap    (min_wrap_s)
    );

    bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hours (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (1'b0),
        .i_Inc     (hour_inc_s),
        .o_Value   (o_Hours),
        .o_Wrap    (hour_wrap_s)
    );

    assign o_Second_Tick = tick_q;

    logic unused_s;
    assign unused_s = hour_wrap_s;

endmodule

// File: tb/tb_time_counters.sv
// Directed bench for time_counters with TICKS_PER_SEC=4 and INC_TICKS=2.
module tb_time_counters;

    logic       clk;
    logic       rst_n;
    logic       crst;
    logic       inc;
    logic [2:0] en;
    logic [7:0] sec, mins, hrs;
    logic       tick;

    int n_checks;
    int n_fail;
    int tick_cnt;
    int tick_mark;

    time_counters #(.TICKS_PER_SEC(4), .INC_TICKS(2)) dut (
        .i_Clock                     (clk),
        .i_Reset_n                   (rst_n),
        .i_Counters_Reset            (crst),
        .i_Counters_Enable_Increment (inc),
        .i_Counters_Enable_Count     (en),
        .o_Seconds                   (sec),
        .o_Minutes                   (mins),
        .o_Hours                     (hrs),
        .o_Second_Tick               (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tick) tick_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        check({tag, "_h"}, {24'h0, hrs},  {24'h0, h});
        check({tag, "_m"}, {24'h0, mins}, {24'h0, m});
        check({tag, "_s"}, {24'h0, sec},  {24'h0, s});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tick_cnt = 0;
        rst_n = 1'b0;
        crst  = 1'($urandom_range(1, 0));
        inc   = 1'($urandom_range(1, 0));
        en    = 3'($urandom_range(7, 0));
        step(1);
        crst = 1'($urandom_range(1, 0));
        inc  = 1'($urandom_range(1, 0));
        en   = 3'($urandom_range(7, 0));
        step(1);
        check_time("reset", 8'h00, 8'h00, 8'h00);
        check("reset_tick", {31'h0, tick}, 32'h0);

        // Release: first tick on the 4th edge
        rst_n = 1'b1; crst = 1'b0; inc = 1'b0; en = 3'b111;
        tick_cnt = 0;
        step(1); check("first_e1_tick", {31'h0, tick}, 32'h0);
        step(1); check("first_e2_tick", {31'h0, tick}, 32'h0);
        step(1); check("first_e3_tick", {31'h0, tick}, 32'h0);
        check("first_e3_sec", {24'h0, sec}, 32'h00);
        step(1); check("first_e4_tick", {31'h0, tick}, 32'h1);
        check("first_e4_sec", {24'h0, sec}, 32'h01);

        // Carry chain up to one hour
        step(14395);
        check_time("pre_hour", 8'h00, 8'h59, 8'h59);
        step(1);
        check_time("one_hour", 8'h01, 8'h00, 8'h00);
        check("one_hour_ticks", tick_cnt, 32'd3600);

        // Counters reset mid-second
        step(120);
        check_time("at_30", 8'h01, 8'h00, 8'h30);
        step(2);
        crst = 1'b1;
        step(1);
        check_time("crst", 8'h01, 8'h00, 8'h00);
        check("crst_tick", {31'h0, tick}, 32'h0);
        crst = 1'b0;
        tick_mark = tick_cnt;
        step(3);
        check("crst_no_early_tick", tick_cnt, tick_mark);
        step(1);
        check("crst_tick_4th", {31'h0, tick}, 32'h1);
        check_time("crst_after", 8'h01, 8'h00, 8'h01);

        // Set minutes from 00:00:00
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1; inc = 1'b1; en = 3'b010;
        tick_mark = tick_cnt;
        step(2);
        check("setmin_first", {24'h0, mins}, 32'h01);
        step(116);
        check("setmin_59", {24'h0, mins}, 32'h59);
        step(2);
        check_time("setmin_wrap", 8'h00, 8'h00, 8'h00);
        check("setmin_no_ticks", tick_cnt, tick_mark);
        step(10);
        check("setmin_05", {24'h0, mins}, 32'h05);

        // Set hours
        en = 3'b100;
        step(46);
        check("sethour_23", {24'h0, hrs}, 32'h23);
        step(2);
        check_time("sethour_wrap", 8'h00, 8'h05, 8'h00);
        inc = 1'b0; en = 3'b000;
        step(20);
        check_time("frozen", 8'h00, 8'h05, 8'h00);
        check("frozen_ticks", tick_cnt, tick_mark);

        // Build 23:59:59 in set mode, then the day wrap in normal mode
        inc = 1'b1; en = 3'b001;
        step(118);
        en = 3'b100;
        step(46);
        en = 3'b010;
        step(108);
        check_time("built", 8'h23, 8'h59, 8'h59);
        inc = 1'b0; en = 3'b111;
        step(3);
        check_time("pre_day", 8'h23, 8'h59, 8'h59);
        step(1);
        check_time("day_wrap", 8'h00, 8'h00, 8'h00);
        check("day_wrap_tick", {31'h0, tick}, 32'h1);

        // Seconds wrap must not carry when the minutes enable is off
        inc = 1'b1; en = 3'b001;
        step(118);
        check("nocarry_sec59", {24'h0, sec}, 32'h59);
        inc = 1'b0;
        step(4);
        check_time("nocarry", 8'h00, 8'h00, 8'h00);

        // Mode switch with the second prescaler at 2
        en = 3'b111;
        step(2);
        inc = 1'b1; en = 3'b000;
        tick_mark = tick_cnt;
        step(3);
        check_time("modesw_set", 8'h00, 8'h00, 8'h00);
        check("modesw_set_ticks", tick_cnt, tick_mark);
        inc = 1'b0; en = 3'b111;
        step(1);
        check("modesw_e1_tick", {31'h0, tick}, 32'h0);
        step(1);
        check("modesw_e2_tick", {31'h0, tick}, 32'h1);
        check("modesw_sec", {24'h0, sec}, 32'h01);

        // Increment prescaler restarts from 0 on re-entry
        inc = 1'b1; en = 3'b010;
        step(1);
        check("reenter_e1", {24'h0, mins}, 32'h00);
        step(1);
        check("reenter_e2", {24'h0, mins}, 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_counters.md
Name: time_counters

Overview:
- Timekeeping datapath driven by the clock's control unit.
- Consumes the unit's counter-control outputs: Reset, Enable_Increment and Enable_Count[2:0].
- Maintains seconds/minutes/hours as packed BCD, in both normal running and manual-set modes.
- Feeds the display driver with time values and a one-cycle per-second tick, used for dot blinking.

Parameters:
- TICKS_PER_SEC, 100_000_000: clock cycles per second; minimum 2.
- INC_TICKS, 50_000_000: clock cycles between manual-set increments; minimum 2.

Ports:
- i_Clock  in  1  system clock; all state updates on its rising edge.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Counters_Reset  in  1  clears seconds and the second prescaler.
- i_Counters_Enable_Increment  in  1  1 = manual-set mode; 0 = normal timekeeping.
- i_Counters_Enable_Count  in  3  field enables: bit0 seconds, bit1 minutes, bit2 hours.
- o_Seconds  out  8  BCD 00-59, registered.
- o_Minutes  out  8  BCD 00-59, registered.
- o_Hours  out  8  BCD 00-23, registered.
- o_Second_Tick  out  1  one-cycle pulse, high in the same cycle seconds advance.

Behaviour:
- Reset (i_Reset_n=0 at an edge):
  - o_Seconds, o_Minutes, o_Hours = 8'h00; o_Second_Tick = 0.
  - Both prescalers = 0.
- Per-edge priority, highest first: i_Reset_n, then i_Counters_Reset, then set mode, then normal mode.
- i_Counters_Reset=1:
  - Seconds = 00, second prescaler = 0, o_Second_Tick = 0.
  - Minutes and hours held.
  - Increment prescaler = 0.
- Normal mode (Enable_Increment=0):
  - Second prescaler counts 0..TICKS_PER_SEC-1 while bit0=1; frozen (not cleared) while bit0=0.
  - At the edge where prescaler==TICKS_PER_SEC-1: prescaler wraps to 0, seconds +1, o_Second_Tick=1 for that one cycle.
  - First advance after reset/clear therefore occurs TICKS_PER_SEC edges later.
  - Seconds 59->00 carries into minutes only if bit1=1.
  - Minutes 59->00 carries into hours only if bit2=1 and a carry arrived.
  - Hours 23->00 wraps with no further carry.
  - Carry is combinational within the same edge; all three fields update together (00:59:59 -> 01:00:00 in one edge).
  - Increment prescaler held at 0.
- Set mode (Enable_Increment=1):
  - Second prescaler frozen; o_Second_Tick=0.
  - Increment prescaler counts 0..INC_TICKS-1; it is 0 on entry, because it is held at 0 outside set mode.
  - At wrap, each field whose enable bit is 1 increments by 1 modulo its range (60/60/24).
  - No carries between fields in set mode.
  - Enable_Count=000 in set mode: prescaler runs, nothing changes.
- BCD rule per field:
  - Ones digit 9->0 increments tens.
  - Full-range wrap (59->00, 23->00) takes precedence.
  - Values never leave the legal BCD range.
- Mode switch mid-count:
  - Leaving set mode clears the increment prescaler.
  - The second prescaler resumes from its frozen value.
- i_Reset_n deasserted mid-operation: the next edge obeys normal priority; no pulse is lost or duplicated on the deasserting edge.

Decomposition:
- Package time_counters_pkg holds:
  - BCD max constants (SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23).
  - Enable bit indices (EN_SEC=0, EN_MIN=1, EN_HOUR=2).
- Sub-module bcd_mod_counter:
  - Parameter MAX_BCD.
  - Inputs i_Clock, i_Reset_n, i_Clear, i_Inc.
  - Outputs o_Value[7:0] and o_Wrap (combinational: i_Inc & value==MAX_BCD).
  - Instantiated three times; the top module holds both prescalers and the mode/carry logic.

Test Plan (TICKS_PER_SEC=4, INC_TICKS=2):
- Reset:
  - Stimulus: i_Reset_n=0 for 2 edges with random other inputs.
  - Response: outputs 00/00/00, tick 0.
  - Then release with En_Count=111, Inc=0; first o_Second_Tick occurs at the 4th edge; seconds=01.
- Carry chain:
  - Stimulus: normal mode, 3600*4 edges after reset.
  - Response: 01:00:00; tick count equals 3600.
  - At 86400*4 edges: 00:00:00.
- Counters reset mid-second:
  - Stimulus: at seconds=30 plus 2 cycles, pulse i_Counters_Reset for 1 cycle.
  - Response: seconds=00; minutes unchanged; next tick exactly 4 edges after deassert.
- Set minutes:
  - Stimulus: Inc=1, En_Count=010 from 00:00:00 for 120 edges.
  - Response: 60 increments; minutes 00->59->00; hours stays 00; no ticks.
- Set hours:
  - Stimulus: Inc=1, En_Count=100 for 48 edges.
  - Response: hours 00..23 then 00; minutes/seconds unchanged.
  - Then Inc=0, En_Count=000 for 20 edges: outputs frozen.
- Mode switch:
  - Stimulus: normal mode, prescaler at 2; Inc=1 with En_Count=000 for 3 edges, then back to normal.
  - Response: next tick 2 edges after return; the prescaler resumed from its frozen value.
